bin2bcd_8d: RTL and testbench
=============================

# bin2bcd_8d

Sequential binary-to-packed-BCD converter feeding the 8-digit seven-segment display driver. It accepts a 27-bit unsigned binary value on a start strobe and converts it iteratively with shift-and-add-3 (double dabble). It presents the result as eight packed BCD digits on a holding register that stays stable between conversions, because the display samples it asynchronously at its scan rate. Out-of-range inputs saturate to 99 999 999 and raise a flag.

## Interface

- DIGITS, 8: number of BCD output digits; bcd width is 4*DIGITS.
- BIN_W, 27: binary input width; requires 2^BIN_W > 10^DIGITS - 1.

- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary operand; captured on the accepting edge.
- bcd  output  4*DIGITS  packed BCD result, MS digit in [4*DIGITS-1 -: 4]; updates only on completion.
- busy  output  1  registered; high while a conversion is in progress.
- done  output  1  registered; one-cycle pulse when bcd has just been updated.
- ovf  output  1  registered; set when the last converted input exceeded 10^DIGITS - 1.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1 at edge E0:
  - capture bin into the low BIN_W bits of the work register;
  - clear the BCD part of the work register;
  - latch the compare result bin > MAX_VAL into ovf_pending;
  - clear the shift counter;
  - go to SHIFT.
- SHIFT, edges E1..E_BIN_W, one iteration per edge:
  - each BCD digit of the work register that is >= 5 gets +3, 4-bit, no carry out;
  - then shift the whole work register left 1;
  - increment the counter;
  - after the BIN_W-th shift, go to DONE.
- DONE, edge E_BIN_W+1:
  - bcd <= ovf_pending ? all-9s : BCD part of work;
  - ovf <= ovf_pending;
  - done <= 1;
  - go to IDLE.
- done clears on the next edge unconditionally.
- start is ignored in SHIFT and DONE; no queueing.
- bin changes after E0 have no effect on the result.
- Width rules:
  - work register width is 4*DIGITS + BIN_W;
  - the counter is wide enough for BIN_W;
  - digit adjust is pure 4-bit, and double dabble guarantees no digit exceeds 9 after the shift.
- Reset (any time, including mid-conversion):
  - state IDLE; bcd = 0; busy = 0; done = 0; ovf = 0; work and counter cleared;
  - an aborted conversion produces no done pulse and does not touch bcd beyond clearing it.

## Timing

- Accepting edge E0 to bcd/done valid: BIN_W+1 edges (28 at default). The done pulse is visible in the cycle after E28.
- busy is high in the cycles after E0 through E28 inclusive, i.e. 28 cycles at default, and low after E28.
- Earliest next accept is E29, so minimum initiation interval is BIN_W+2 edges (29).
- With start held high, a new conversion is accepted at E29, and done falls at that same edge.
- bcd and ovf change only at the DONE edge and at reset. No glitch-free guarantees are needed beyond registering.

## Structure

- Package bin2bcd_pkg holds:
  - FSM state typedef (IDLE, SHIFT, DONE);
  - MAX_VAL_8D = 27'd99_999_999;
  - SAT_BCD_8D = 32'h9999_9999;
  - a function returning 10^DIGITS - 1 for parameterised compare.
- Sub-module bcd_digit_adj: combinational 4-bit "if >= 5 then +3". It is instantiated DIGITS times via generate.
- bin2bcd_8d top holds the FSM, counter, work register and output registers.

## Test plan

- Reset: assert rst asynchronously mid-cycle -> bcd=32'h0, busy=0, done=0, ovf=0 immediately.
- bin=0, start pulse -> busy high 28 cycles; done single pulse at E28; bcd=32'h0000_0000, ovf=0.
- bin=12_345_678 -> bcd=32'h1234_5678 at E28, ovf=0. Then bin=9 -> bcd=32'h0000_0009, and bcd holds 1234_5678 until that second E28.
- Saturation:
  - bin=99_999_999 -> 32'h9999_9999, ovf=0;
  - bin=100_000_000 -> 32'h9999_9999, ovf=1;
  - bin=27'h7FF_FFFF -> 32'h9999_9999, ovf=1;
  - next bin=42 -> 32'h0000_0042, ovf=0.
- start held high, bin changed every cycle -> accepts exactly every 29 cycles. Each result matches bin at its accepting edge, and starts during busy are ignored.
- Start bin=87_654_321, assert rst at cycle 10 -> busy=0, bcd=0, no done pulse. A fresh start with bin=5 -> 32'h0000_0005 after 28 cycles.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-packed-BCD converter.
// Holds the FSM state type, the 8-digit saturation constants and the 10^N-1 helper.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [26:0] MAX_VAL_8D = 27'd99_999_999;
  localparam logic [31:0] SAT_BCD_8D = 32'h9999_9999;

  // Largest value representable in 'digits' decimal digits; evaluated at elaboration
  function automatic logic [63:0] max_dec(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle between a requester and the bin2bcd converter.
// The converter takes the slave modport; the requester drives start/bin.
interface bin2bcd_if #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  ovf;

  modport master (
    output start, bin,
    input  bcd, busy, done, ovf
  );

  modport slave (
    input  start, bin,
    output bcd, busy, done, ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
// Pure 4-bit arithmetic; the algorithm guarantees the carry out is never needed.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_8d.sv
// Iterative shift-and-add-3 converter: one bit per clock, result held in a stable
// register between conversions so the display scanner can sample it at any time.
module bin2bcd_8d
  import bin2bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
) (
  input  logic       clk,
  input  logic       rst,
  bin2bcd_if.slave   bus
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  localparam logic [63:0]      MAX_VAL = max_dec(DIGITS);
  localparam logic [BCD_W-1:0] SAT_BCD = {DIGITS{4'h9}};

  state_t              state;
  state_t              state_nx;
  logic                load;
  logic                shift_en;
  logic                finish;
  logic                last_shift;

  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   work_adj;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_pending;

  logic [BCD_W-1:0]    bcd_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;

  // The binary half passes through untouched; each BCD nibble gets its own adjuster
  assign work_adj[BIN_W-1:0] = work[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (work[BIN_W + 4*g +: 4]),
      .digit_out (work_adj[BIN_W + 4*g +: 4])
    );
  end

  assign last_shift = (cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_shift) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Out-of-range inputs are detected at capture and saturated only when publishing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work        <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        work        <= {{BCD_W{1'b0}}, bus.bin};
        cnt         <= '0;
        ovf_pending <= (64'(bus.bin) > MAX_VAL);
        busy_q      <= 1'b1;
      end
      if (shift_en) begin
        work <= work_adj << 1;
        cnt  <= cnt + CNT_W'(1);
      end
      if (finish) begin
        bcd_q  <= ovf_pending ? SAT_BCD : work[WORK_W-1 -: BCD_W];
        ovf_q  <= ovf_pending;
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_8d.sv
// Directed-vector bench for bin2bcd_8d: table of conversions with hand-computed results,
// plus hand-written sequences for async reset, aborted conversion and held start.
module tb_bin2bcd_8d;

  typedef struct {
    logic [26:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bin2bcd_if #(.DIGITS(8), .BIN_W(27)) bif ();

  bin2bcd_8d #(.DIGITS(8), .BIN_W(27)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference conversion by repeated division, saturating above 99 999 999
  function automatic logic [31:0] model_bcd(input logic [26:0] b);
    int unsigned v;
    logic [31:0] r;
    v = 32'(b);
    r = '0;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [26:0] held_bin(input int j);
    return 27'(j * 1_543_211 + 7);
  endfunction

  task automatic applyStimulus(input logic [26:0] b);
    @(negedge clk);
    bif.bin   = b;
    bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
  endtask

  // Runs one conversion, scrambling bin while busy, and checks timing, hold and result
  task automatic runVector(input string tag, input logic [26:0] b, input logic [31:0] exp_bcd,
                           input logic exp_ovf, input logic [31:0] prev_bcd);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = 0;
    bit hold_ok  = 1'b1;
    applyStimulus(b);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (bif.busy) busy_cnt++;
      if (bif.done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k <= 28 && bif.bcd !== prev_bcd) hold_ok = 1'b0;
      bif.bin = 27'($urandom);
    end
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd28);
    checkOutput({tag, "_done_cycle"},  64'(done_at),  64'd29);
    checkOutput({tag, "_done_count"},  64'(done_cnt), 64'd1);
    checkOutput({tag, "_bcd_hold"},    64'(hold_ok),  64'd1);
    checkOutput({tag, "_bcd"},         64'(bif.bcd),  64'(exp_bcd));
    checkOutput({tag, "_ovf"},         64'(bif.ovf),  64'(exp_ovf));
  endtask

  initial begin
    logic [31:0] prev;
    int          abort_done;

    vecs[0]  = '{27'd0,           32'h0000_0000, 1'b0};
    vecs[1]  = '{27'd12_345_678,  32'h1234_5678, 1'b0};
    vecs[2]  = '{27'd9,           32'h0000_0009, 1'b0};
    vecs[3]  = '{27'd99_999_999,  32'h9999_9999, 1'b0};
    vecs[4]  = '{27'd100_000_000, 32'h9999_9999, 1'b1};
    vecs[5]  = '{27'h7FF_FFFF,    32'h9999_9999, 1'b1};
    vecs[6]  = '{27'd42,          32'h0000_0042, 1'b0};
    vecs[7]  = '{27'd1,           32'h0000_0001, 1'b0};
    vecs[8]  = '{27'd99,          32'h0000_0099, 1'b0};
    vecs[9]  = '{27'd65_535,      32'h0006_5535, 1'b0};
    vecs[10] = '{27'd100_000_000, 32'h9999_9999, 1'b1};

    rst       = 1'b1;
    bif.start = 1'b0;
    bif.bin   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_bcd",  64'(bif.bcd),  64'h0);
    checkOutput("reset_busy", 64'(bif.busy), 64'h0);
    checkOutput("reset_done", 64'(bif.done), 64'h0);
    checkOutput("reset_ovf",  64'(bif.ovf),  64'h0);
    rst = 1'b0;

    prev = 32'h0;
    for (int i = 0; i < 11; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf, prev);
      prev = vecs[i].bcd;
    end

    $display("[TB] async reset mid-cycle");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_bcd",  64'(bif.bcd),  64'h0);
    checkOutput("async_busy", 64'(bif.busy), 64'h0);
    checkOutput("async_done", 64'(bif.done), 64'h0);
    checkOutput("async_ovf",  64'(bif.ovf),  64'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] aborted conversion");
    applyStimulus(27'd87_654_321);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(bif.busy), 64'h0);
    checkOutput("abort_bcd",  64'(bif.bcd),  64'h0);
    @(negedge clk);
    rst = 1'b0;
    abort_done = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (bif.done) abort_done++;
    end
    checkOutput("abort_no_done",   64'(abort_done), 64'h0);
    checkOutput("abort_bcd_after", 64'(bif.bcd),    64'h0);
    runVector("fresh5", 27'd5, 32'h0000_0005, 1'b0, 32'h0);

    $display("[TB] start held high");
    for (int j = 0; j <= 87; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        int p;
        bit exp_done;
        p        = j - 1;
        exp_done = (p % 29 == 28);
        checkOutput($sformatf("held_done_e%0d", p), 64'(bif.done), 64'(exp_done));
        checkOutput($sformatf("held_busy_e%0d", p), 64'(bif.busy), 64'(!exp_done));
        if (exp_done) begin
          checkOutput($sformatf("held_bcd_e%0d", p), 64'(bif.bcd), 64'(model_bcd(held_bin(p - 28))));
          checkOutput($sformatf("held_ovf_e%0d", p), 64'(bif.ovf), 64'h0);
        end
      end
      if (j <= 86) begin
        bif.start = 1'b1;
        bif.bin   = held_bin(j);
      end else begin
        bif.start = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
